md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multiply/divide unit in the EX stage of the 5-stage MIPS pipeline. Owns the architectural HI/LO registers.
- Executes mult, multu, div, divu, mthi and mtlo.
- Drives the busy indication that the hazard/stall controller in ID uses to freeze any md-class instruction (mult/div/mfhi/mflo/mthi/mtlo) while an operation is in flight.
- mfhi/mflo read the hi/lo outputs combinationally through the EX result mux.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15).

Ports:
- clk  input  1  pipeline clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  EX-stage instruction is valid and md-class; qualifies md_op.
- md_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- rs_val  input  32  forwarded rs operand.
- rt_val  input  32  forwarded rt operand.
- busy  output  1  registered; an operation is in flight.
- md_stall  output  1  combinational: busy OR (start AND md_op in 1..4). The stall controller ORs this into its stop term for md-class instructions in ID.
- hi  output  32  architectural HI.
- lo  output  32  architectural LO.

Behaviour:
- Reset (async, reset==0): hi=0, lo=0, busy=0, cnt=0, pending results cleared, state IDLE.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, 4-bit down-counter cnt.
- IDLE, start=1, md_op 1..4, sampled at edge E:
  - Compute the result from rs_val/rt_val at E and latch it into pend_hi/pend_lo.
  - Load cnt = N-1 (N = MULT_CYCLES or DIV_CYCLES) and go to RUN.
  - busy is high for exactly N cycles after E.
- RUN: decrement cnt each edge. At the edge where cnt==0, commit pend_hi/pend_lo to hi/lo, set busy=0, go to IDLE. New hi/lo are visible in the same cycle busy is first low.
- Arithmetic:
  - mult: signed 32x32->64, {hi,lo}=product.
  - multu: unsigned 32x32->64, {hi,lo}=product.
  - div: lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero (rt_val==0, div or divu): busy sequence runs normally, and hi/lo are left unchanged at commit.
- mthi/mtlo in IDLE: hi (or lo) <= rs_val at E. No busy, other register untouched.
- start while RUN: ignored entirely. The counter, pending results and hi/lo are unaffected. This is a protocol violation the stall controller prevents; the unit must still be robust to it.
- md_op 0 or 7 with start=1: no effect.
- hi/lo never change except at commit, mthi/mtlo or reset.
- Reset asserted mid-RUN: immediate return to the reset values, and the pending result is discarded.

Optional Feature:
- Macro MD_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit), asserted by exception/flush logic.
  - abort=1 at an edge while RUN: go to IDLE, busy=0 after that edge, pending result discarded, hi/lo unchanged.
  - abort=1 coinciding with start in IDLE: start suppressed (mthi/mtlo also suppressed).
  - abort at the commit edge (cnt==0): abort wins, no commit.
- Undefined: no abort port; every started operation always commits.

Test Plan:
- Reset, then start mult rs=0xFFFFFFFE (-2), rt=3 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA with busy=0.
- multu rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 5 busy cycles hi=0xFFFFFFFE, lo=0x00000001.
- div rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then divu rs=7, rt=0 -> busy 10 cycles, hi/lo unchanged.
- mthi rs=0x12345678 in IDLE -> hi=0x12345678 next cycle, busy stays 0, lo unchanged. Then mtlo during a running mult -> ignored, mult result commits.
- Assert reset (low) at the 3rd busy cycle of div -> hi=lo=0 and busy=0 immediately; later ops behave normally.
- MD_ABORT_EN: abort in the 2nd busy cycle of mult -> busy=0 next cycle, hi/lo keep prior values. md_stall check: start+div in IDLE -> md_stall=1 combinationally that cycle.

Source files
------------

// File: rtl/md_unit.sv
// ============================================================================
// Module   : md_unit
// Brief    : EX-stage multiply/divide unit owning HI/LO; optional abort via MD_ABORT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
`ifdef MD_ABORT_EN
  input  logic        abort,
`endif
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] c_op_mult  = 3'd1;
  localparam logic [2:0] c_op_multu = 3'd2;
  localparam logic [2:0] c_op_div   = 3'd3;
  localparam logic [2:0] c_op_divu  = 3'd4;
  localparam logic [2:0] c_op_mthi  = 3'd5;
  localparam logic [2:0] c_op_mtlo  = 3'd6;

  localparam logic [3:0] c_mult_last = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] c_div_last  = 4'(DIV_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_pend_hi;
  logic [31:0] r_pend_lo;
  logic        r_pend_wr;
  logic        r_busy;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_abort;
  logic        w_is_arith;
  logic        w_is_div;
  logic        w_div_signed;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_rs_neg;
  logic        w_rt_neg;
  logic [31:0] w_dvd;
  logic [31:0] w_dvs;
  logic [31:0] w_dvs_safe;
  logic        w_div_zero;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;

`ifdef MD_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_is_arith   = (md_op >= c_op_mult) && (md_op <= c_op_divu);
  assign w_is_div     = (md_op == c_op_div) || (md_op == c_op_divu);
  assign w_div_signed = (md_op == c_op_div);

  assign w_prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
  assign w_prod_u = {32'd0, rs_val} * {32'd0, rt_val};

  // Signed divide goes through one unsigned divider on magnitudes; the
  // 0x80000000 / -1 case falls out naturally as quotient 0x80000000.
  assign w_rs_neg   = w_div_signed & rs_val[31];
  assign w_rt_neg   = w_div_signed & rt_val[31];
  assign w_dvd      = w_rs_neg ? (32'd0 - rs_val) : rs_val;
  assign w_dvs      = w_rt_neg ? (32'd0 - rt_val) : rt_val;
  assign w_div_zero = (rt_val == 32'd0);
  assign w_dvs_safe = w_div_zero ? 32'd1 : w_dvs;
  assign w_q_mag    = w_dvd / w_dvs_safe;
  assign w_r_mag    = w_dvd % w_dvs_safe;
  assign w_quot     = (w_rs_neg ^ w_rt_neg) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_rem      = w_rs_neg ? (32'd0 - w_r_mag) : w_r_mag;

  always_comb begin
    w_res_hi = w_prod_s[63:32];
    w_res_lo = w_prod_s[31:0];
    if (md_op == c_op_multu) begin
      w_res_hi = w_prod_u[63:32];
      w_res_lo = w_prod_u[31:0];
    end else if (w_is_div) begin
      w_res_hi = w_rem;
      w_res_lo = w_quot;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 4'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_pend_wr <= 1'b0;
      r_busy    <= 1'b0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start && !w_abort) begin
            if (w_is_arith) begin
              r_pend_hi <= w_res_hi;
              r_pend_lo <= w_res_lo;
              r_pend_wr <= !(w_is_div && w_div_zero);
              r_cnt     <= w_is_div ? c_div_last : c_mult_last;
              r_busy    <= 1'b1;
              r_state   <= ST_RUN;
            end else if (md_op == c_op_mthi) begin
              r_hi <= rs_val;
            end else if (md_op == c_op_mtlo) begin
              r_lo <= rs_val;
            end
          end
        end
        ST_RUN: begin
          // A start arriving here is a protocol violation and is ignored.
          if (w_abort) begin
            r_pend_wr <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= ST_IDLE;
          end else if (r_cnt == 4'd0) begin
            if (r_pend_wr) begin
              r_hi <= r_pend_hi;
              r_lo <= r_pend_lo;
            end
            r_pend_wr <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign md_stall = r_busy | (start & w_is_arith);
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_md_unit.sv
// ============================================================================
// Module   : tb_md_unit
// Brief    : Self-checking bench for md_unit: vector table plus scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_md_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;
`ifdef MD_ABORT_EN
  logic        abort;
`endif

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
`ifdef MD_ABORT_EN
    .abort    (abort),
`endif
    .start    (start),
    .md_op    (md_op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .busy     (busy),
    .md_stall (md_stall),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  vec_t        tbl[9];
  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] ch,
                                        input logic [31:0] cl);
    logic signed [63:0] sa, sb64;
    logic [63:0]        ua, ub;
    logic signed [31:0] qa, qb;
    sa = $signed(a); sb64 = $signed(b);
    ua = {32'd0, a}; ub = {32'd0, b};
    qa = $signed(a); qb = $signed(b);
    case (op)
      3'd1: return 64'(sa * sb64);
      3'd2: return ua * ub;
      3'd3: begin
        if (b == 32'd0) return {ch, cl};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {32'(qa % qb), 32'(qa / qb)};
      end
      3'd4: begin
        if (b == 32'd0) return {ch, cl};
        return {a % b, a / b};
      end
      default: return {ch, cl};
    endcase
  endfunction

  // Drives one arithmetic op and counts busy cycles; inj plants an mtlo in the 2nd busy cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input bit inj,
                        input string nm);
    exp_t e;
    int   n;
    e.hi = eh; e.lo = el; e.cyc = (op >= 3'd3) ? 10 : 5;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b1; md_op = op; rs_val = a; rt_val = b;
    #1 chk({nm, " stall_start"}, 32'(md_stall), 32'd1);
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd0;
    chk({nm, " stall_busy"}, 32'(md_stall), 32'd1);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (inj && n == 2) begin
        start = 1'b1; md_op = 3'd6; rs_val = 32'hDEAD_BEEF;
      end else begin
        start = 1'b0; md_op = 3'd0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (sb.size() == 0) begin
      chk({nm, " scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({nm, " busy_cycles"}, 32'(n), 32'(e.cyc));
      chk({nm, " hi"}, hi, e.hi);
      chk({nm, " lo"}, lo, e.lo);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r;
    logic [2:0]  op;
    logic [31:0] a, b;

    tbl[0] = '{3'd1, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA};
    tbl[1] = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    tbl[2] = '{3'd3, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[3] = '{3'd4, 32'd7,         32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[4] = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    tbl[5] = '{3'd4, 32'd100,       32'd7,        32'd2,         32'd14};
    tbl[6] = '{3'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    tbl[7] = '{3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};
    tbl[8] = '{3'd3, 32'd5,         32'd0,        32'h3FFF_FFFF, 32'h0000_0001};

    reset = 1'b0; start = 1'b0; md_op = 3'd0; rs_val = 32'd0; rt_val = 32'd0;
`ifdef MD_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset stall", 32'(md_stall), 32'd0);
    @(negedge clk) reset = 1'b1;

    for (int i = 0; i < 9; i++)
      run_op(tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].hi, tbl[i].lo, 1'b0,
             $sformatf("vec%0d", i));
    m_hi = tbl[8].hi; m_lo = tbl[8].lo;

    for (int i = 0; i < 6; i++) begin
      op = 3'(1 + (i % 4));
      a  = $urandom;
      b  = (i % 2 == 1) ? $urandom : $urandom_range(1, 300);
      r  = model(op, a, b, m_hi, m_lo);
      run_op(op, a, b, r[63:32], r[31:0], 1'b0, $sformatf("rnd%0d", i));
      m_hi = r[63:32]; m_lo = r[31:0];
    end

    // mthi in IDLE: no stall, no busy, LO untouched
    @(negedge clk);
    start = 1'b1; md_op = 3'd5; rs_val = 32'h1234_5678;
    #1 chk("mthi stall", 32'(md_stall), 32'd0);
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd0;
    chk("mthi hi", hi, 32'h1234_5678);
    chk("mthi lo", lo, m_lo);
    chk("mthi busy", 32'(busy), 32'd0);

    run_op(3'd1, 32'h0000_1234, 32'h10, 32'd0, 32'h0001_2340, 1'b1, "mtlo_in_run");

    // Reset asserted during the 3rd busy cycle of a div
    @(negedge clk);
    start = 1'b1; md_op = 3'd3; rs_val = 32'd100; rt_val = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midreset hi", hi, 32'd0);
    chk("midreset lo", lo, 32'd0);
    chk("midreset busy", 32'(busy), 32'd0);
    @(negedge clk) reset = 1'b1;
    run_op(3'd1, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, "post_reset");

`ifdef MD_ABORT_EN
    @(negedge clk);
    start = 1'b1; md_op = 3'd1; rs_val = 32'd3; rt_val = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd0;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("abort hi", hi, 32'd0);
    chk("abort lo", lo, 32'd42);
    @(negedge clk);
    start = 1'b1; md_op = 3'd5; rs_val = 32'hCAFE_0000; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd0; abort = 1'b0;
    chk("abort mthi hi", hi, 32'd0);
    chk("abort mthi busy", 32'(busy), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
